// File: rtl/axi_slave_decerr_pkg.sv
// Shared types and constants for the AXI DECERR terminator (package axi_pkg).
// Optional error counters are enabled by defining AXI_DECERR_CNT_EN.
package axi_pkg;

   // AXI response encodings
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   // Error counter geometry
   localparam int unsigned CNT_WIDTH = 16;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } wr_state_t;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } rd_state_t;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/axi_slave_decerr_if.sv
// AXI4 write/read channel bundle seen by the DECERR terminator.
// master drives requests and response-ready; slave drives ready and responses.
interface axi_slave_decerr_if #(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32
);

   // Write address channel
   logic [ID_WIDTH-1:0]     WR_ADDR_ID;
   logic [ADDR_WIDTH-1:0]   WR_ADDR;
   logic [7:0]              WR_ADDR_LEN;
   logic                    WR_ADDR_VALID;
   logic                    WR_ADDR_READY;

   // Write data channel
   logic [DATA_WIDTH-1:0]   WR_DATA;
   logic [DATA_WIDTH/8-1:0] WR_DATA_STRB;
   logic                    WR_DATA_LAST;
   logic                    WR_DATA_VALID;
   logic                    WR_DATA_READY;

   // Write response channel
   logic [ID_WIDTH-1:0]     WR_BACK_ID;
   logic [1:0]              WR_BACK_RESP;
   logic                    WR_BACK_VALID;
   logic                    WR_BACK_READY;

   // Read address channel
   logic [ID_WIDTH-1:0]     RD_ADDR_ID;
   logic [ADDR_WIDTH-1:0]   RD_ADDR;
   logic [7:0]              RD_ADDR_LEN;
   logic                    RD_ADDR_VALID;
   logic                    RD_ADDR_READY;

   // Read data channel
   logic [ID_WIDTH-1:0]     RD_BACK_ID;
   logic [DATA_WIDTH-1:0]   RD_DATA;
   logic [1:0]              RD_DATA_RESP;
   logic                    RD_DATA_LAST;
   logic                    RD_DATA_VALID;
   logic                    RD_DATA_READY;

   modport master (
      output WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_VALID,
      input  WR_ADDR_READY,
      output WR_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
      input  WR_DATA_READY,
      input  WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
      output WR_BACK_READY,
      output RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_VALID,
      input  RD_ADDR_READY,
      input  RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
      output RD_DATA_READY
   );

   modport slave (
      input  WR_ADDR_ID, WR_ADDR, WR_ADDR_LEN, WR_ADDR_VALID,
      output WR_ADDR_READY,
      input  WR_DATA, WR_DATA_STRB, WR_DATA_LAST, WR_DATA_VALID,
      output WR_DATA_READY,
      output WR_BACK_ID, WR_BACK_RESP, WR_BACK_VALID,
      input  WR_BACK_READY,
      input  RD_ADDR_ID, RD_ADDR, RD_ADDR_LEN, RD_ADDR_VALID,
      output RD_ADDR_READY,
      output RD_BACK_ID, RD_DATA, RD_DATA_RESP, RD_DATA_LAST, RD_DATA_VALID,
      input  RD_DATA_READY
   );

endinterface

// File: rtl/axi_slave_decerr.sv
// AXI4 terminator for an unpopulated interconnect slot: accepts every burst and
// completes it with DECERR. Independent write and read FSMs, one outstanding
// transaction per channel. Define AXI_DECERR_CNT_EN to add saturating 16-bit
// WR_ERR_CNT / RD_ERR_CNT outputs.
module axi_slave_decerr
   import axi_pkg::*;
#(
   parameter int unsigned ID_WIDTH   = 4,
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 32,
   parameter logic [31:0] RD_FILL    = 32'hDEAD_BEEF
) (
   input  logic              CLK,
   input  logic              RSTN,
   axi_slave_decerr_if.slave bus
`ifdef AXI_DECERR_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0] WR_ERR_CNT,
   output logic [CNT_WIDTH-1:0] RD_ERR_CNT
`endif
);

   // Fill pattern replicated up to DATA_WIDTH, then truncated
   localparam int unsigned FILL_REPS = (DATA_WIDTH + 31) / 32;
   localparam logic [FILL_REPS*32-1:0] FILL_REP  = {FILL_REPS{RD_FILL}};
   localparam logic [DATA_WIDTH-1:0]   FILL_WORD = FILL_REP[DATA_WIDTH-1:0];

   // Payload fields that are accepted but never looked at
   logic [ADDR_WIDTH-1:0] unused_wr_addr;
   logic [ADDR_WIDTH-1:0] unused_rd_addr;
   logic                  unused_payload;
   assign unused_wr_addr = bus.WR_ADDR;
   assign unused_rd_addr = bus.RD_ADDR;
   assign unused_payload = ^{bus.WR_ADDR_LEN, bus.WR_DATA, bus.WR_DATA_STRB};

   // ------------------------------------------------------------------
   // Output enable: keeps IDLE-state READYs low while reset is asserted,
   // so every output is 0 in reset yet still decodes from flops only.
   // ------------------------------------------------------------------
   logic out_en_q;

   // Rises on the first clock after reset release
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) out_en_q <= 1'b0;
      else       out_en_q <= 1'b1;
   end

   // ------------------------------------------------------------------
   // Write channel
   // ------------------------------------------------------------------
   wr_state_t           wr_state_q, wr_state_d;
   logic [ID_WIDTH-1:0] wr_id_q;

   logic                wr_addr_ready;
   logic                wr_data_ready;
   logic                wr_back_valid;
   logic [1:0]          wr_back_resp;
   logic [ID_WIDTH-1:0] wr_back_id;

   logic aw_hs, w_hs, b_hs;
   assign aw_hs = bus.WR_ADDR_VALID & wr_addr_ready;
   assign w_hs  = bus.WR_DATA_VALID & wr_data_ready;
   assign b_hs  = wr_back_valid & bus.WR_BACK_READY;

   // Write state register and AW id capture
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_state_q <= W_IDLE;
         wr_id_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         if (aw_hs) wr_id_q <= bus.WR_ADDR_ID;
      end
   end

   // Write next state: WLAST, not AWLEN, ends the data phase
   always_comb begin
      wr_state_d = wr_state_q;
      unique case (wr_state_q)
         W_IDLE:  if (aw_hs) wr_state_d = W_DATA;
         W_DATA:  if (w_hs && bus.WR_DATA_LAST) wr_state_d = W_RESP;
         W_RESP:  if (b_hs) wr_state_d = W_IDLE;
         default: wr_state_d = W_IDLE;
      endcase
   end

   // Write outputs, decoded from registered state only
   always_comb begin
      wr_addr_ready = 1'b0;
      wr_data_ready = 1'b0;
      wr_back_valid = 1'b0;
      wr_back_resp  = RESP_OKAY;
      wr_back_id    = '0;
      unique case (wr_state_q)
         W_IDLE: wr_addr_ready = out_en_q;
         W_DATA: wr_data_ready = 1'b1;
         W_RESP: begin
            wr_back_valid = 1'b1;
            wr_back_resp  = RESP_DECERR;
            wr_back_id    = wr_id_q;
         end
         default: ;
      endcase
   end

   assign bus.WR_ADDR_READY = wr_addr_ready;
   assign bus.WR_DATA_READY = wr_data_ready;
   assign bus.WR_BACK_VALID = wr_back_valid;
   assign bus.WR_BACK_RESP  = wr_back_resp;
   assign bus.WR_BACK_ID    = wr_back_id;

   // ------------------------------------------------------------------
   // Read channel
   // ------------------------------------------------------------------
   rd_state_t           rd_state_q, rd_state_d;
   logic [ID_WIDTH-1:0] rd_id_q;
   logic [7:0]          rd_len_q;
   logic [7:0]          rd_cnt_q;
   logic                rd_last;

   logic                rd_addr_ready;
   logic                rd_data_valid;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [1:0]          rd_data_resp;
   logic                rd_data_last;
   logic [ID_WIDTH-1:0] rd_back_id;

   logic ar_hs, r_hs;
   assign ar_hs   = bus.RD_ADDR_VALID & rd_addr_ready;
   assign r_hs    = rd_data_valid & bus.RD_DATA_READY;
   assign rd_last = (rd_cnt_q == rd_len_q);

   // Read state register plus burst id/len/beat-count tracking
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         rd_state_q <= R_IDLE;
         rd_id_q    <= '0;
         rd_len_q   <= '0;
         rd_cnt_q   <= '0;
      end else begin
         rd_state_q <= rd_state_d;
         if (ar_hs) begin
            rd_id_q  <= bus.RD_ADDR_ID;
            rd_len_q <= bus.RD_ADDR_LEN;
            rd_cnt_q <= '0;
         end else if (r_hs && !rd_last) begin
            // Never advances past len, so len=255 cannot wrap
            rd_cnt_q <= rd_cnt_q + 8'd1;
         end
      end
   end

   // Read next state: the beat carrying LAST closes the burst
   always_comb begin
      rd_state_d = rd_state_q;
      unique case (rd_state_q)
         R_IDLE:  if (ar_hs) rd_state_d = R_DATA;
         R_DATA:  if (r_hs && rd_last) rd_state_d = R_IDLE;
         default: rd_state_d = R_IDLE;
      endcase
   end

   // Read outputs, decoded from registered state only
   always_comb begin
      rd_addr_ready = 1'b0;
      rd_data_valid = 1'b0;
      rd_data       = '0;
      rd_data_resp  = RESP_OKAY;
      rd_data_last  = 1'b0;
      rd_back_id    = '0;
      unique case (rd_state_q)
         R_IDLE: rd_addr_ready = out_en_q;
         R_DATA: begin
            rd_data_valid = 1'b1;
            rd_data       = FILL_WORD;
            rd_data_resp  = RESP_DECERR;
            rd_data_last  = rd_last;
            rd_back_id    = rd_id_q;
         end
         default: ;
      endcase
   end

   assign bus.RD_ADDR_READY = rd_addr_ready;
   assign bus.RD_DATA_VALID = rd_data_valid;
   assign bus.RD_DATA       = rd_data;
   assign bus.RD_DATA_RESP  = rd_data_resp;
   assign bus.RD_DATA_LAST  = rd_data_last;
   assign bus.RD_BACK_ID    = rd_back_id;

`ifdef AXI_DECERR_CNT_EN
   // ------------------------------------------------------------------
   // Completed-transaction error counters
   // ------------------------------------------------------------------
   logic [CNT_WIDTH-1:0] wr_err_cnt_q;
   logic [CNT_WIDTH-1:0] rd_err_cnt_q;

   // Count B handshakes and final R beats, saturating at all-ones
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         wr_err_cnt_q <= '0;
         rd_err_cnt_q <= '0;
      end else begin
         if (b_hs)            wr_err_cnt_q <= sat_inc(wr_err_cnt_q);
         if (r_hs && rd_last) rd_err_cnt_q <= sat_inc(rd_err_cnt_q);
      end
   end

   assign WR_ERR_CNT = wr_err_cnt_q;
   assign RD_ERR_CNT = rd_err_cnt_q;
`endif

endmodule

// File: doc/axi_slave_decerr.md
Name: axi_slave_decerr

Overview:
- Protocol-complete AXI4 terminator for unpopulated interconnect slave slots, replacing the silent tie-off that leaves masters hung.
- Accepts every write and read burst and completes each one with a DECERR response.
- Independent write and read channel FSMs; one outstanding transaction per channel.
- Sits directly downstream of the AXI interconnect slave port.

Parameters:
- ID_WIDTH, 4, width of all ID fields
- ADDR_WIDTH, 32, address width (address accepted, ignored)
- DATA_WIDTH, 32, data width
- RD_FILL, 32'hDEAD_BEEF, constant driven on RD_DATA (replicated/truncated to DATA_WIDTH)

Ports:
- CLK  in  1  clock
- RSTN  in  1  asynchronous active-low reset
- WR_ADDR_ID  in  ID_WIDTH  AW id
- WR_ADDR  in  ADDR_WIDTH  AW address, ignored
- WR_ADDR_LEN  in  8  AW beats-1, ignored (WLAST governs)
- WR_ADDR_VALID / WR_ADDR_READY  in / out  1  AW handshake
- WR_DATA  in  DATA_WIDTH  discarded
- WR_DATA_STRB  in  DATA_WIDTH/8  discarded
- WR_DATA_LAST  in  1  final W beat
- WR_DATA_VALID / WR_DATA_READY  in / out  1  W handshake
- WR_BACK_ID  out  ID_WIDTH  B id
- WR_BACK_RESP  out  2  B response
- WR_BACK_VALID / WR_BACK_READY  out / in  1  B handshake
- RD_ADDR_ID  in  ID_WIDTH  AR id
- RD_ADDR  in  ADDR_WIDTH  ignored
- RD_ADDR_LEN  in  8  AR beats-1
- RD_ADDR_VALID / RD_ADDR_READY  in / out  1  AR handshake
- RD_BACK_ID  out  ID_WIDTH  R id
- RD_DATA  out  DATA_WIDTH  fill pattern
- RD_DATA_RESP  out  2  R response
- RD_DATA_LAST  out  1  final R beat
- RD_DATA_VALID / RD_DATA_READY  out / in  1  R handshake

Behaviour:
- Reset (RSTN low, async): both FSMs to IDLE.
  - All outputs 0, RD_DATA included; RESP outputs 2'b00 in reset and whenever the matching VALID is low.
  - Reset mid-burst aborts the burst with no response.
- Handshake: a transfer occurs on the rising CLK edge where VALID and READY are both 1.
  - All READY/VALID outputs decode from registered state only; no combinational path from any input.
- Write FSM W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: WR_ADDR_READY=1. On AW handshake, latch WR_ADDR_ID and go to W_DATA.
  - W_DATA: WR_DATA_READY=1; each beat is discarded. On a handshake with WR_DATA_LAST=1, go to W_RESP.
  - W_RESP: WR_BACK_VALID=1, WR_BACK_RESP=2'b11, WR_BACK_ID=latched id; held stable until WR_BACK_READY. On B handshake, return to W_IDLE.
- Write latency:
  - AW handshake at cycle N -> WR_DATA_READY at N+1.
  - Last W at M -> WR_BACK_VALID at M+1.
  - B handshake at K -> WR_ADDR_READY at K+1.
- Write boundary conditions:
  - W valid before AW: WR_DATA_READY stays 0 until AW is accepted.
  - A new AW while busy waits (WR_ADDR_READY=0).
- Read FSM R_IDLE -> R_DATA:
  - R_IDLE: RD_ADDR_READY=1. On AR handshake, latch id and len, clear the 8-bit beat counter, go to R_DATA.
  - R_DATA: RD_DATA_VALID=1, RD_DATA=RD_FILL, RD_DATA_RESP=2'b11, RD_BACK_ID=latched id, RD_DATA_LAST=(cnt==len).
  - Outputs hold stable while RD_DATA_READY=0. Each handshake increments cnt; the handshake with LAST returns to R_IDLE.
- Read latency and counting:
  - AR at N -> first RD_DATA_VALID at N+1.
  - len 0 gives one beat with LAST; len 255 gives 256 beats, and the counter never wraps before LAST.
- Channel independence: simultaneous AW and AR are both accepted the same cycle; the write and read FSMs never interact.

Optional Feature:
- Macro AXI_DECERR_CNT_EN.
- Defined: adds outputs WR_ERR_CNT and RD_ERR_CNT (16 bits each), reset to 0.
  - WR_ERR_CNT increments on each B handshake; RD_ERR_CNT increments on each R handshake with LAST.
  - Both saturate at 16'hFFFF.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package axi_pkg: RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11; enum wr_state_t {W_IDLE,W_DATA,W_RESP}; enum rd_state_t {R_IDLE,R_DATA}.
- No sub-module: two always_ff FSMs plus output decode in a single module.

Test Plan:
- AW id=3 len=3 then 4 W beats (WLAST on 4th), BREADY=1 -> WR_BACK_VALID one cycle after last W; RESP=2'b11, ID=3; WR_ADDR_READY high the cycle after B handshake.
- AR id=5 len=7, RREADY=1 -> 8 beats on consecutive cycles, RD_DATA=32'hDEADBEEF, RESP=2'b11, ID=5; LAST only on beat 8; RD_ADDR_READY=0 throughout.
- AR len=0 with RREADY toggling 0/1 -> single beat with LAST, held stable across stall cycles; len=255 -> exactly 256 beats.
- W beats presented 3 cycles before AW -> WR_DATA_READY=0 until the cycle after AW handshake; same-cycle AW and AR both accepted.
- RSTN asserted mid read burst (beat 3 of 8) -> all outputs 0 immediately; after release RD_ADDR_READY=1 and the next AR returns a full fresh burst.
- With AXI_DECERR_CNT_EN: 2 writes and 3 reads -> WR_ERR_CNT=2, RD_ERR_CNT=3; forced counter value 16'hFFFF stays at 16'hFFFF after a further write.
